// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
// Arbiter FSM encoding and byte width.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr.
// Whole ring is searched in one combinational pass.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] cand;

  // Walk the ring backwards so the entry nearest ptr wins last.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = W'((int'(ptr) + k) % N);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter in front of one UART transmitter.
// Optional stall timeout: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int IDW         = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           cts,
  output logic [UART_BYTE_W-1:0]         tx_data,
  output logic                           tx_valid,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic [IDW-1:0]                 grant_id,
  output logic                           locked,
  output logic                           timeout_err
);

  arb_state_t state;
  arb_state_t nextState;

  logic [IDW-1:0] grantId;
  logic [IDW-1:0] rrPtr;
  logic [IDW-1:0] nextPtr;
  logic [IDW-1:0] pickIdx;
  logic           pickAny;

  logic [UART_BYTE_W-1:0] reqBytes [NUM_REQ];
  logic [UART_BYTE_W-1:0] txDataQ;

  logic grantValid;
  logic grantLast;
  logic lastLatched;
  logic fire;
  logic relGrant;
  logic timeoutHit;

  for (genvar i = 0; i < NUM_REQ; i++) begin : gBytes
    assign reqBytes[i] = req_data[i*UART_BYTE_W +: UART_BYTE_W];
  end

  rr_pick #(
    .N(NUM_REQ),
    .W(IDW)
  ) uPick (
    .req(req_valid),
    .ptr(rrPtr),
    .idx(pickIdx),
    .any(pickAny)
  );

  assign grantValid = req_valid[grantId];
  assign grantLast  = req_last[grantId];
  assign nextPtr    = (grantId == IDW'(NUM_REQ - 1)) ? '0 : grantId + 1'b1;

  assign tx_valid = fire & ~reset;
  assign tx_data  = txDataQ;
  assign grant_id = grantId;
  assign locked   = (state != IDLE);

  // One-hot accept pulse for the holder, only when a byte launches.
  always_comb begin
    req_ready = '0;
    if (tx_valid) req_ready[grantId] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state and handshake decode.
  always_comb begin
    nextState = state;
    fire      = 1'b0;
    relGrant  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pickAny) nextState = ISSUE;
      end
      ISSUE: begin
        if (grantValid && cts && !tx_busy) begin
          fire      = 1'b1;
          nextState = WAIT_BUSY;
        end else if (timeoutHit) begin
          relGrant  = 1'b1;
          nextState = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (tx_done) begin
          relGrant  = lastLatched;
          nextState = lastLatched ? IDLE : ISSUE;
        end else if (tx_busy) begin
          nextState = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          relGrant  = lastLatched;
          nextState = lastLatched ? IDLE : ISSUE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Grant, pointer and launched-byte registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      grantId     <= '0;
      rrPtr       <= '0;
      txDataQ     <= '0;
      lastLatched <= 1'b0;
    end else begin
      if (state == IDLE && pickAny) grantId <= pickIdx;
      if (fire) begin
        txDataQ     <= reqBytes[grantId];
        lastLatched <= grantLast;
      end
      if (relGrant) rrPtr <= nextPtr;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] idleCnt;
  logic             timeoutErrQ;

  assign timeoutHit  = (state == ISSUE) && !grantValid &&
                       (idleCnt == CNT_W'(TIMEOUT_CYC - 1));
  assign timeout_err = timeoutErrQ;

  // Count holder starvation cycles; any launch restarts the count.
  always_ff @(posedge clk) begin
    if (reset)                         idleCnt <= '0;
    else if (state != ISSUE || fire)   idleCnt <= '0;
    else if (!grantValid)              idleCnt <= idleCnt + 1'b1;
  end

  // Sticky flag for a forced release.
  always_ff @(posedge clk) begin
    if (reset)           timeoutErrQ <= 1'b0;
    else if (timeoutHit) timeoutErrQ <= 1'b1;
  end
`else
  assign timeoutHit  = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter.
// Reference model arbitrates whole packets over bench-side queues.
module tb_uart_tx_arbiter;

  localparam int NUM = 4;

  typedef struct {
    int         id;
    logic [7:0] d;
  } exp_t;

  logic            clk;
  logic            reset;
  logic [NUM-1:0]  req_valid;
  logic [8*NUM-1:0] req_data;
  logic [NUM-1:0]  req_last;
  logic [NUM-1:0]  req_ready;
  logic            cts;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_busy;
  logic            tx_done;
  logic [1:0]      grant_id;
  logic            locked;
  logic            timeout_err;

  int vectors     = 0;
  int miscompares = 0;
  int txvCount    = 0;
  int modelPtr    = 0;

  logic [7:0] qData [NUM][$];
  bit         qLast [NUM][$];
  bit         midPkt [NUM];
  exp_t       expQ [$];

  bit forceAll = 1'b1;
  bit ctsHold  = 1'b0;
  bit randCts  = 1'b0;
  bit randTx   = 1'b0;
  bit dropEn   = 1'b0;

  uart_tx_arbiter #(
    .NUM_REQ(NUM),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .cts(cts),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .grant_id(grant_id),
    .locked(locked),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic bit qEmpty();
    for (int i = 0; i < NUM; i++)
      if (qData[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic addByte(input int i, input logic [7:0] d, input bit last);
    qData[i].push_back(d);
    qLast[i].push_back(last);
  endtask

  // Packet-level round robin: the winner sends its whole packet (up to
  // its last flag, or until its source runs dry), then the pointer moves
  // one past the winner.
  task automatic runModel();
    int  pos [NUM];
    int  p;
    int  j;
    bit  found;
    bit  done;
    for (int i = 0; i < NUM; i++) pos[i] = 0;
    p = modelPtr;
    forever begin
      found = 1'b0;
      for (int k = 0; k < NUM && !found; k++) begin
        j = (p + k) % NUM;
        if (pos[j] < qData[j].size()) begin
          found = 1'b1;
          done  = 1'b0;
          while (!done) begin
            expQ.push_back('{id: j, d: qData[j][pos[j]]});
            done = qLast[j][pos[j]];
            pos[j]++;
            if (pos[j] >= qData[j].size()) done = 1'b1;
          end
          p = (j + 1) % NUM;
        end
      end
      if (!found) break;
    end
    modelPtr = p;
  endtask

  task automatic waitDone(input string nm);
    int cyc = 0;
    while (!(expQ.size() == 0 && !locked && qEmpty()) && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 6000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d bytes outstanding, required 0",
               nm, expQ.size());
      expQ.delete();
      for (int i = 0; i < NUM; i++) begin
        qData[i].delete();
        qLast[i].delete();
      end
    end
  endtask

  task automatic waitExp(input int n, input string nm);
    int cyc = 0;
    while (expQ.size() > n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_wait: %0d bytes outstanding, required %0d",
               nm, expQ.size(), n);
    end
  endtask

  // Requester sources: present queue heads, pop on accept.
  initial begin
    logic [NUM-1:0] rdy;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    cts       = 1'b1;
    forever begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM; i++) begin
        if (rdy[i] && qData[i].size() > 0) begin
          midPkt[i] = !qLast[i][0];
          void'(qData[i].pop_front());
          void'(qLast[i].pop_front());
        end
      end
      for (int i = 0; i < NUM; i++) begin
        if (forceAll)
          req_valid[i] = 1'b1;
        else if (qData[i].size() > 0)
          req_valid[i] = !(dropEn && midPkt[i] && ($urandom % 4 == 0));
        else
          req_valid[i] = 1'b0;
        if (qData[i].size() > 0) begin
          req_data[i*8 +: 8] = qData[i][0];
          req_last[i]        = qLast[i][0];
        end else begin
          req_data[i*8 +: 8] = 8'($urandom);
          req_last[i]        = 1'($urandom);
        end
      end
      if (ctsHold)      cts = 1'b0;
      else if (randCts) cts = ($urandom % 5 != 0);
      else              cts = 1'b1;
    end
  end

  // Transmitter model: busy for a frame, then a done pulse.
  initial begin
    int mode;
    int len;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_valid) begin
        mode = randTx ? int'($urandom_range(0, 2)) : 0;
        len  = randTx ? int'($urandom_range(1, 8)) : 10;
        @(posedge clk);
        #1;
        if (mode == 2) begin
          tx_busy = 1'b1;
          tx_done = 1'b1;
        end else begin
          tx_busy = 1'b1;
          repeat (len) @(posedge clk);
          #1;
          if (mode == 0) tx_busy = 1'b0;
          tx_done = 1'b1;
        end
        @(posedge clk);
        #1;
        tx_busy = 1'b0;
        tx_done = 1'b0;
      end
    end
  end

  // Monitor: every launch pops the scoreboard.
  initial begin
    exp_t       e;
    bit         chkPending = 1'b0;
    logic [7:0] pendD = '0;
    forever begin
      @(negedge clk);
      if (chkPending) begin
        check("tx_data", tx_data, pendD);
        chkPending = 1'b0;
      end
      if (tx_valid) begin
        txvCount++;
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_tx_valid: got grant %0d, required none",
                   grant_id);
        end else begin
          e = expQ.pop_front();
          check("grant_id", grant_id, e.id);
          check("req_ready", req_ready, 32'(1) << e.id);
          check("cts_at_issue", cts, 1);
          pendD      = e.d;
          chkPending = 1'b1;
        end
      end else if (req_ready != '0) begin
        check("req_ready_idle", req_ready, 0);
      end
    end
  end

  initial begin
    int t0;
    reset = 1'b1;

    // Reset with every requester asserting.
    repeat (3) begin
      @(negedge clk);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_locked", locked, 0);
      check("rst_timeout_err", timeout_err, 0);
    end
    forceAll = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Single two-byte packet from requester 0.
    #1;
    addByte(0, 8'hA5, 1'b0);
    addByte(0, 8'h3C, 1'b1);
    runModel();
    waitDone("single");

    // Contention between requesters 1 and 3.
    #1;
    for (int b = 0; b < 3; b++) addByte(1, 8'h10 + 8'(b), b == 2);
    for (int b = 0; b < 3; b++) addByte(3, 8'h30 + 8'(b), b == 2);
    runModel();
    waitDone("contention");

    // cts held low for 50 cycles mid-packet.
    #1;
    for (int b = 0; b < 4; b++) addByte(2, 8'hC0 + 8'(b), b == 3);
    runModel();
    waitExp(3, "flow");
    ctsHold = 1'b1;
    t0 = txvCount;
    repeat (50) @(negedge clk);
    check("flow_no_issue", txvCount, t0);
    check("flow_grant_id", grant_id, 2);
    check("flow_locked", locked, 1);
    ctsHold = 1'b0;
    waitDone("flow");

    // Pointer wrap: requester 3 ahead of requester 0.
    #1;
    addByte(0, 8'h01, 1'b0);
    addByte(0, 8'h02, 1'b1);
    addByte(3, 8'h3F, 1'b1);
    runModel();
    waitDone("wrap");

`ifdef UART_ARB_TIMEOUT_EN
    // Holder stalls after a non-last byte; forced release.
    #1;
    addByte(2, 8'h77, 1'b0);
    addByte(0, 8'h11, 1'b0);
    addByte(0, 8'h22, 1'b1);
    runModel();
    waitDone("timeout");
    check("timeout_err_set", timeout_err, 1);
`endif

    // Randomized packet mixes with stalls and varied frame timing.
    randCts = 1'b1;
    randTx  = 1'b1;
    dropEn  = 1'b1;
    for (int ph = 0; ph < 25; ph++) begin
      int npk;
      int len;
      #1;
      for (int i = 0; i < NUM; i++) begin
        midPkt[i] = 1'b0;
        npk = int'($urandom_range(0, 2));
        for (int p = 0; p < npk; p++) begin
          len = int'($urandom_range(1, 4));
          for (int b = 0; b < len; b++)
            addByte(i, 8'($urandom), b == len - 1);
        end
      end
      runModel();
      waitDone("random");
    end
    randCts = 1'b0;
    randTx  = 1'b0;
    dropEn  = 1'b0;

    // Reset while a frame is in flight.
    #1;
    addByte(1, 8'h5A, 1'b0);
    addByte(1, 8'h6B, 1'b1);
    runModel();
    waitExp(1, "midreset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      qData[i].delete();
      qLast[i].delete();
    end
    expQ.delete();
    repeat (2) @(negedge clk);
    check("midrst_locked", locked, 0);
    check("midrst_grant_id", grant_id, 0);
    check("midrst_tx_valid", tx_valid, 0);
    reset    = 1'b0;
    modelPtr = 0;
    repeat (20) @(negedge clk);

    // Pointer restarts at 0 after reset.
    #1;
    addByte(3, 8'hE3, 1'b1);
    addByte(0, 8'hE0, 1'b1);
    runModel();
    waitDone("post_reset");

`ifndef UART_ARB_TIMEOUT_EN
    check("timeout_err_tied", timeout_err, 0);
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
